// File: rtl/dmem_pkg.sv
// Shared data-SRAM port definitions: default widths, read-return owner encoding
// and the active-low strobe levels.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 7;
   localparam int DMEM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_CPU = 2'd1,
      RD_DMA = 2'd2
   } rd_owner_t;

   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of consecutive cycles the DMA port has waited; force_gnt flags the limit.
// Latency: force_gnt is registered-state only; no backpressure, the counter just clears on grant or drop.
module dmem_starve_cnt #(
   parameter int STARVE_LIM = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic dma_req,
   input  logic dma_gnt,
   output logic force_gnt
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] LIM_V = CNT_W'(STARVE_LIM);

   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (!dma_req || dma_gnt) begin
         wait_cnt <= '0;
      end else if (wait_cnt != LIM_V) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign force_gnt = (wait_cnt == LIM_V);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the data SRAM: CPU priority, DMA force-granted after STARVE_LIM waits.
// Latency: grant and SRAM drive same cycle, read data one cycle later; losers are held via cpu_stall / ~dma_gnt.
module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W     = DMEM_ADDR_W,
   parameter int DATA_W     = DMEM_DATA_W,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              CEN,
   output logic              WEN,
   output logic              OEN,
   output logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] Data2Mem,
   input  logic [DATA_W-1:0] ReadDataMem
);

   logic      force_gnt;
   logic      cpu_gnt;
   rd_owner_t state_q, state_d;

   dmem_starve_cnt #(
      .STARVE_LIM(STARVE_LIM)
   ) u_starve_cnt (
      .clk      (clk),
      .rst      (rst),
      .dma_req  (dma_req),
      .dma_gnt  (dma_gnt),
      .force_gnt(force_gnt)
   );

   // Gating with rst drops the SRAM strobes the instant reset asserts.
   assign dma_gnt   = dma_req & ~rst & (~cpu_req | force_gnt);
   assign cpu_gnt   = cpu_req & ~rst & ~dma_gnt;
   assign cpu_stall = cpu_req & ~cpu_gnt;

   always_comb begin
      CEN      = STROBE_OFF;
      WEN      = STROBE_OFF;
      OEN      = STROBE_OFF;
      A        = '0;
      Data2Mem = '0;
      if (cpu_gnt) begin
         CEN = STROBE_ON;
         A   = cpu_addr;
         if (cpu_we) begin
            WEN      = STROBE_ON;
            Data2Mem = cpu_wdata;
         end else begin
            OEN = STROBE_ON;
         end
      end else if (dma_gnt) begin
         CEN = STROBE_ON;
         A   = dma_addr;
         if (dma_we) begin
            WEN      = STROBE_ON;
            Data2Mem = dma_wdata;
         end else begin
            OEN = STROBE_ON;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next owner depends only on this cycle's grant, so a new read overlaps the previous return.
   always_comb begin
      state_d = IDLE;
      if (cpu_gnt && !cpu_we) begin
         state_d = RD_CPU;
      end else if (dma_gnt && !dma_we) begin
         state_d = RD_DMA;
      end
   end

   assign cpu_rvalid = (state_q == RD_CPU);
   assign dma_rvalid = (state_q == RD_DMA);
   assign cpu_rdata  = cpu_rvalid ? ReadDataMem : '0;
   assign dma_rdata  = dma_rvalid ? ReadDataMem : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: SRAM behavioural model on the pins plus a
// transaction-level reference model of arbitration, memory contents and read returns.
module tb_dmem_port_arbiter;

   localparam int SL = 4;

   logic        clk;
   logic        rst;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [6:0]  cpu_addr, dma_addr;
   logic [31:0] cpu_wdata, dma_wdata;
   logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
   logic [31:0] cpu_rdata, dma_rdata;
   logic        CEN, WEN, OEN;
   logic [6:0]  A;
   logic [31:0] Data2Mem, ReadDataMem;

   dmem_port_arbiter #(.ADDR_W(7), .DATA_W(32), .STARVE_LIM(SL)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
      .ReadDataMem(ReadDataMem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int i);
      if (i == 5) return 32'hDEADBEEF;
      return 32'hC0DE0000 + 32'(i) * 32'h00000101;
   endfunction

   // SRAM on the pins: synchronous write, read data registered for the next cycle.
   logic        mem_init;
   logic [31:0] sram [128];
   logic [31:0] rd_q;
   assign ReadDataMem = rd_q;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 128; i++) sram[i] <= pat(i);
         rd_q <= 32'h0;
      end else if (!CEN) begin
         if (!WEN) sram[A] <= Data2Mem;
         else if (!OEN) rd_q <= sram[A];
      end
   end

   // Reference model state
   logic [31:0] ref_mem [128];
   int          m_wait;
   int          m_owner;   // 0 none, 1 cpu, 2 dma
   logic [31:0] m_rdata;
   logic        last_cg, last_dg;

   logic        obs_dgnt, obs_stall, obs_crv, obs_drv, obs_cen, obs_wen, obs_oen;
   logic [6:0]  obs_a;
   logic [31:0] obs_crd, obs_drd;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: check outputs at the negedge against the model, advance the model at posedge.
   task automatic do_cycle();
      logic       e_dg, e_cg, e_cen, e_wen, e_oen, e_we;
      logic [6:0] e_a;
      logic [31:0] e_d;
      @(negedge clk);
      e_dg  = !rst && dma_req && (!cpu_req || m_wait >= SL);
      e_cg  = !rst && cpu_req && !e_dg;
      e_cen = !(e_cg || e_dg);
      e_we  = e_cg ? cpu_we : dma_we;
      e_wen = e_cen ? 1'b1 : !e_we;
      e_oen = e_cen ? 1'b1 : e_we;
      e_a   = e_cg ? cpu_addr : (e_dg ? dma_addr : 7'h0);
      e_d   = e_cg ? cpu_wdata : dma_wdata;
      chk("dma_gnt", {31'b0, dma_gnt}, {31'b0, e_dg});
      chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req && !e_cg});
      chk("CEN", {31'b0, CEN}, {31'b0, e_cen});
      chk("WEN", {31'b0, WEN}, {31'b0, e_wen});
      chk("OEN", {31'b0, OEN}, {31'b0, e_oen});
      chk("A", {25'b0, A}, {25'b0, e_a});
      if (!e_cen && e_we) chk("Data2Mem", Data2Mem, e_d);
      chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, m_owner == 1});
      chk("cpu_rdata", cpu_rdata, (m_owner == 1) ? m_rdata : 32'h0);
      chk("dma_rvalid", {31'b0, dma_rvalid}, {31'b0, m_owner == 2});
      chk("dma_rdata", dma_rdata, (m_owner == 2) ? m_rdata : 32'h0);
      obs_dgnt = dma_gnt; obs_stall = cpu_stall; obs_cen = CEN; obs_wen = WEN;
      obs_oen = OEN; obs_a = A; obs_crv = cpu_rvalid; obs_crd = cpu_rdata;
      obs_drv = dma_rvalid; obs_drd = dma_rdata;
      last_cg = e_cg; last_dg = e_dg;
      @(posedge clk);
      m_owner = 0;
      if (rst) begin
         m_wait = 0;
      end else begin
         if (e_cg && !cpu_we) begin m_owner = 1; m_rdata = ref_mem[cpu_addr]; end
         if (e_dg && !dma_we) begin m_owner = 2; m_rdata = ref_mem[dma_addr]; end
         if (e_cg && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
         if (e_dg && dma_we) ref_mem[dma_addr] = dma_wdata;
         m_wait = (dma_req && !e_dg) ? ((m_wait < SL) ? m_wait + 1 : SL) : 0;
      end
      #1;
   endtask

   task automatic set_cpu(input logic req, input logic we, input logic [6:0] a, input logic [31:0] d);
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_dma(input logic req, input logic we, input logic [6:0] a, input logic [31:0] d);
      dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
   endtask

   initial begin
      rst = 1'b1; mem_init = 1'b0;
      set_cpu(0, 0, 7'h0, 32'h0);
      set_dma(0, 0, 7'h0, 32'h0);
      for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);
      m_wait = 0; m_owner = 0; m_rdata = 32'h0;
      do_cycle();
      do_cycle();
      chk("rst_cen", {31'b0, CEN}, 32'd1);
      chk("rst_rvalid", {30'b0, cpu_rvalid, dma_rvalid}, 32'd0);
      rst = 1'b0; mem_init = 1'b1;

      // CPU-only load of the preloaded word
      set_cpu(1, 0, 7'h05, 32'h0);
      do_cycle();
      chk("t1_cen_oen_a", {23'b0, obs_cen, obs_oen, obs_a}, {23'b0, 1'b0, 1'b0, 7'h05});
      chk("t1_stall", {31'b0, obs_stall}, 32'd0);
      set_cpu(0, 0, 7'h0, 32'h0);
      do_cycle();
      chk("t1_rvalid", {31'b0, obs_crv}, 32'd1);
      chk("t1_rdata", obs_crd, 32'hDEADBEEF);

      // Contention: CPU loads 0x01 continuously, DMA reads 0x02 until forced
      set_cpu(1, 0, 7'h01, 32'h0);
      set_dma(1, 0, 7'h02, 32'h0);
      for (int c = 0; c < 6; c++) begin
         if (c == 5) set_dma(0, 0, 7'h0, 32'h0);
         do_cycle();
         chk($sformatf("t2_dgnt_c%0d", c), {31'b0, obs_dgnt}, {31'b0, c == 4});
         chk($sformatf("t2_stall_c%0d", c), {31'b0, obs_stall}, {31'b0, c == 4});
         if (c == 4) chk("t4_cpu_rdata", obs_crd, pat(1));
         if (c == 5) begin
            chk("t4_cpu_rvalid", {31'b0, obs_crv}, 32'd0);
            chk("t4_dma_rvalid", {31'b0, obs_drv}, 32'd1);
            chk("t4_dma_rdata", obs_drd, pat(2));
         end
      end
      set_cpu(0, 0, 7'h0, 32'h0);
      do_cycle();

      // DMA write then CPU read of the same word
      set_dma(1, 1, 7'h10, 32'h12345678);
      do_cycle();
      chk("t3_wen", {31'b0, obs_wen}, 32'd0);
      set_dma(0, 0, 7'h0, 32'h0);
      set_cpu(1, 0, 7'h10, 32'h0);
      do_cycle();
      chk("t3_oen", {31'b0, obs_oen}, 32'd0);
      set_cpu(0, 0, 7'h0, 32'h0);
      do_cycle();
      chk("t3_rdata", obs_crd, 32'h12345678);
      chk("t3_no_dma_rvalid", {31'b0, obs_drv}, 32'd0);

      // Reset right after a CPU read grant, with DMA already waiting
      set_cpu(1, 0, 7'h03, 32'h0);
      set_dma(1, 0, 7'h04, 32'h0);
      do_cycle();
      rst = 1'b1;
      #1;
      chk("t5_rvalid", {31'b0, cpu_rvalid}, 32'd0);
      chk("t5_strobes", {29'b0, CEN, WEN, OEN}, 32'd7);
      m_owner = 0; m_wait = 0;
      set_cpu(0, 0, 7'h0, 32'h0);
      set_dma(0, 0, 7'h0, 32'h0);
      do_cycle();
      rst = 1'b0;
      set_cpu(1, 0, 7'h06, 32'h0);
      set_dma(1, 0, 7'h07, 32'h0);
      for (int c = 0; c < 5; c++) begin
         do_cycle();
         chk($sformatf("t5_dgnt_c%0d", c), {31'b0, obs_dgnt}, {31'b0, c == 4});
      end
      set_cpu(0, 0, 7'h0, 32'h0);
      set_dma(0, 0, 7'h0, 32'h0);

      // Idle
      for (int c = 0; c < 10; c++) begin
         do_cycle();
         if (c > 0)
            chk("t6_idle", {27'b0, obs_cen, obs_crv, obs_drv, obs_dgnt, obs_stall}, 32'h10);
      end

      // Randomized traffic on a small address window to provoke hazards and starvation
      for (int c = 0; c < 400; c++) begin
         if (cpu_req && !last_cg && $urandom_range(0, 15) != 0) begin
            // hold pending CPU request
         end else begin
            set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    7'($urandom_range(0, 7)), $urandom);
         end
         if (dma_req && !last_dg && $urandom_range(0, 15) != 0) begin
            // hold pending DMA request
         end else begin
            set_dma($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    7'($urandom_range(0, 7)), $urandom);
         end
         do_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
